// File: rtl/demux_1to8_reg.sv
// demux_1to8_reg: registered 1-to-8 demultiplexer with per-slot valid bits.
// Writes land either in the slot chosen by S (addressed mode) or in the slot
// named by an internal wrapping pointer (sequential mode). A consumer ack
// releases all slots at once; an ack and a write on the same edge behave as
// "clear, then write". Slot data is only ever changed by a write.
module demux_1to8_reg #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst,       // asynchronous, active-low
  input  logic         en,
  input  logic [N-1:0] I,
  input  logic [2:0]   S,
  input  logic         mode,
  input  logic         in_valid,
  input  logic         out_ack,
  output logic [N-1:0] O0,
  output logic [N-1:0] O1,
  output logic [N-1:0] O2,
  output logic [N-1:0] O3,
  output logic [N-1:0] O4,
  output logic [N-1:0] O5,
  output logic [N-1:0] O6,
  output logic [N-1:0] O7,
  output logic [7:0]   valid,
  output logic [2:0]   ptr,
  output logic         in_ready,
  output logic         full
);

  // Occupancy state; always a pure function of the valid vector.
  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_FILLING = 2'b01;
  localparam logic [1:0] ST_FULL    = 2'b10;

  logic [N-1:0] slot_q [8];
  logic [N-1:0] slot_d [8];
  logic [7:0]   valid_q, valid_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [1:0]   state_q, state_d;
  logic [2:0]   target;
  logic         ack;
  logic         wr;

  // Handshake: ack only counts when enabled; a full buffer accepts a write
  // only when the same cycle's ack frees it.
  always_comb begin
    ack      = en & out_ack;
    in_ready = en & (~full | out_ack);
    wr       = in_valid & in_ready;
  end

  // Next-state: apply the ack clear first, then the (optional) write.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default up front so
    // no path through the block leaves it unassigned (which would infer a latch).
    slot_d  = slot_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    target  = S;

    if (ack) begin
      valid_d = '0;
      ptr_d   = '0;
    end

    if (wr) begin
      // Sequential mode uses the post-clear pointer, so ack+write lands in slot 0.
      target          = mode ? ptr_d : S;
      slot_d[target]  = I;
      valid_d[target] = 1'b1;
      if (mode) begin
        ptr_d = ptr_d + 3'd1;  // 3-bit add wraps 7 -> 0
      end
    end

    if (valid_d == 8'h00) begin
      state_d = ST_EMPTY;
    end else if (valid_d == 8'hFF) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_FILLING;
    end
  end

  // State registers; reset clears everything immediately, including slot data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the slot storage is reset too, because the outputs must read
      // zero the moment reset is asserted, not merely be marked invalid.
      for (int k = 0; k < 8; k++) begin
        slot_q[k] <= '0;
      end
      valid_q <= '0;
      ptr_q   <= '0;
      state_q <= ST_EMPTY;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      slot_q  <= slot_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      state_q <= state_d;
    end
  end

  // Registered outputs.
  always_comb begin
    O0    = slot_q[0];
    O1    = slot_q[1];
    O2    = slot_q[2];
    O3    = slot_q[3];
    O4    = slot_q[4];
    O5    = slot_q[5];
    O6    = slot_q[6];
    O7    = slot_q[7];
    valid = valid_q;
    ptr   = ptr_q;
    full  = (state_q == ST_FULL);
  end

endmodule

// File: tb/tb_demux_1to8_reg.sv
// tb_demux_1to8_reg: directed scenarios plus randomized traffic, all checked
// against a slot-array reference model kept in the bench.
module tb_demux_1to8_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] I;
  logic [2:0]   S;
  logic         mode;
  logic         in_valid;
  logic         out_ack;
  logic [W-1:0] O0, O1, O2, O3, O4, O5, O6, O7;
  logic [7:0]   valid;
  logic [2:0]   ptr;
  logic         in_ready;
  logic         full;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: eight data slots, eight valid flags, an integer pointer.
  logic [W-1:0] m_data [8];
  bit           m_valid [8];
  int           m_ptr;

  demux_1to8_reg #(.N(W)) dut (
    .clk(clk), .rst(rst), .en(en), .I(I), .S(S), .mode(mode),
    .in_valid(in_valid), .out_ack(out_ack),
    .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6), .O7(O7),
    .valid(valid), .ptr(ptr), .in_ready(in_ready), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_full();
    for (int k = 0; k < 8; k++) if (!m_valid[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] m_valid_vec();
    logic [7:0] v = '0;
    for (int k = 0; k < 8; k++) v[k] = m_valid[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_data[k]  = '0;
      m_valid[k] = 1'b0;
    end
    m_ptr = 0;
  endtask

  // One rising edge of the reference behaviour, using the inputs held across it.
  task automatic model_edge();
    bit was_full;
    int tgt;
    if (!en) return;
    was_full = m_full();
    if (out_ack) begin
      for (int k = 0; k < 8; k++) m_valid[k] = 1'b0;
      m_ptr = 0;
    end
    if (in_valid && (!was_full || out_ack)) begin
      tgt = mode ? m_ptr : int'(S);
      m_data[tgt]  = I;
      m_valid[tgt] = 1'b1;
      if (mode) m_ptr = (m_ptr + 1) % 8;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [W-1:0] o_arr [8];
    bit exp_ready;
    o_arr = '{O0, O1, O2, O3, O4, O5, O6, O7};
    exp_ready = en && (!m_full() || out_ack);
    for (int k = 0; k < 8; k++) check($sformatf("%s_O%0d", tag, k), 32'(o_arr[k]), 32'(m_data[k]));
    check({tag, "_valid"}, 32'(valid), 32'(m_valid_vec()));
    check({tag, "_ptr"}, 32'(ptr), 32'(m_ptr));
    check({tag, "_full"}, 32'(full), 32'(m_full()));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
  endtask

  task automatic set_in(input bit e, input bit iv, input bit ack, input bit md,
                        input logic [2:0] s, input logic [W-1:0] d);
    en = e; in_valid = iv; out_ack = ack; mode = md; S = s; I = d;
  endtask

  // Advance one edge; inputs must already be applied. Sampling is 1 ns after the edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 0, 0, 0, 3'd0, '0);
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Sequential fill 0x10..0x17, then a dropped ninth write.
    for (int k = 0; k < 8; k++) begin
      set_in(1, 1, 0, 1, 3'd0, W'(8'h10 + k));
      cycle("seqfill");
    end
    check("fill_valid", 32'(valid), 32'h0FF);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ptr", 32'(ptr), 32'd0);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_O7", 32'(O7), 32'h17);
    set_in(1, 1, 0, 1, 3'd0, 8'h99);
    cycle("drop9");
    check("drop9_O0", 32'(O0), 32'h10);
    check("drop9_valid", 32'(valid), 32'h0FF);

    // Ack with a simultaneous sequential write from full.
    set_in(1, 1, 1, 1, 3'd0, 8'h3C);
    cycle("ackwr");
    check("ackwr_valid", 32'(valid), 32'h01);
    check("ackwr_O0", 32'(O0), 32'h3C);
    check("ackwr_ptr", 32'(ptr), 32'd1);
    check("ackwr_full", 32'(full), 32'd0);
    check("ackwr_O1_kept", 32'(O1), 32'h11);

    // Enable freeze for three cycles.
    set_in(0, 1, 1, 1, 3'd3, 8'h55);
    repeat (3) cycle("freeze");
    check("freeze_valid", 32'(valid), 32'h01);
    check("freeze_ptr", 32'(ptr), 32'd1);
    check("freeze_in_ready", 32'(in_ready), 32'd0);

    // Addressed write then overwrite of slot 5.
    set_in(1, 0, 1, 0, 3'd0, '0);
    cycle("ack_only");
    set_in(1, 1, 0, 0, 3'd5, 8'hA5);
    cycle("addr_a");
    set_in(1, 1, 0, 0, 3'd5, 8'h5A);
    cycle("addr_b");
    check("addr_O5", 32'(O5), 32'h5A);
    check("addr_valid", 32'(valid), 32'h20);
    check("addr_full", 32'(full), 32'd0);
    check("addr_ptr", 32'(ptr), 32'd0);

    // Mode switching mid-fill.
    set_in(1, 0, 1, 1, 3'd0, '0);
    cycle("ack2");
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 0, 1, 3'd0, W'(8'h40 + k));
      cycle("mix_seq");
    end
    check("mix_ptr3", 32'(ptr), 32'd3);
    set_in(1, 1, 0, 0, 3'd7, 8'h77);
    cycle("mix_addr");
    set_in(1, 1, 0, 1, 3'd0, 8'h43);
    cycle("mix_seq2");
    check("mix_valid", 32'(valid), 32'h8F);
    check("mix_ptr4", 32'(ptr), 32'd4);

    // Asynchronous reset between edges with valid=0F, ptr=4.
    set_in(1, 0, 1, 1, 3'd0, '0);
    cycle("ack3");
    for (int k = 0; k < 4; k++) begin
      set_in(1, 1, 0, 1, 3'd0, W'(8'hC0 + k));
      cycle("pre_rst");
    end
    check("pre_rst_valid", 32'(valid), 32'h0F);
    check("pre_rst_ptr", 32'(ptr), 32'd4);
    set_in(1, 0, 0, 1, 3'd0, '0);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    check("async_rst_O0", 32'(O0), 32'd0);
    check("async_rst_valid", 32'(valid), 32'd0);
    #1;
    rst = 1'b1;
    set_in(1, 1, 0, 1, 3'd0, 8'h77);
    cycle("post_rst");
    check("post_rst_O0", 32'(O0), 32'h77);
    check("post_rst_ptr", 32'(ptr), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
             1'($urandom), 3'($urandom), W'($urandom));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
